// File: rtl/stream_prefetcher.sv
`default_nettype none
// ============================================================================
// Module   : stream_prefetcher
// Brief    : Sequential-stream prefetcher between the L1 miss port and L2, with
//            a small fully-associative buffer of prefetched lines. Optional
//            hit/issue/useless counters are enabled by PREFETCH_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module stream_prefetcher #(
    parameter int ADDR_W     = 32,
    parameter int LINE_BYTES = 32,
    parameter int DATA_W     = 256,
    parameter int DEPTH      = 2,
    parameter int PAGE_BYTES = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              l1_mem_read,
    input  logic              l1_mem_write,
    input  logic [ADDR_W-1:0] l1_mem_address,
    input  logic [DATA_W-1:0] l1_mem_wdata,
    output logic              l1_mem_resp,
    output logic [DATA_W-1:0] l1_mem_rdata,
    output logic              l2_mem_read,
    output logic              l2_mem_write,
    output logic [ADDR_W-1:0] l2_mem_address,
    output logic [DATA_W-1:0] l2_mem_wdata,
    input  logic              l2_mem_resp,
    input  logic [DATA_W-1:0] l2_mem_rdata
`ifdef PREFETCH_STATS_EN
    ,
    output logic [31:0]       stat_hits,
    output logic [31:0]       stat_issued,
    output logic [31:0]       stat_useless
`endif
);

    localparam int c_off_w = $clog2(LINE_BYTES);
    localparam int c_tag_w = ADDR_W - c_off_w;
    localparam int c_cnt_w = $clog2(DEPTH + 1);
    localparam int c_idx_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_cnt_w-1:0] c_depth_cnt = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
    localparam logic [c_tag_w-1:0] c_tag_one   = c_tag_w'(1);
    // Line-index bits that select a line within a page.
    localparam logic [c_tag_w-1:0] c_pg_mask   = c_tag_w'(PAGE_BYTES / LINE_BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEMAND   = 2'd1,
        ST_WRITE    = 2'd2,
        ST_PREFETCH = 2'd3
    } state_t;

    state_t               r_state;
    logic [DEPTH-1:0]     r_valid;
    logic [c_tag_w-1:0]   r_tag  [DEPTH];
    logic [DATA_W-1:0]    r_data [DEPTH];
    logic [c_tag_w-1:0]   r_pf_tag;
    logic [c_cnt_w-1:0]   r_pf_cnt;
    logic [c_idx_w-1:0]   r_alloc;

    logic [c_tag_w-1:0]   w_l1_tag;
    logic [DEPTH-1:0]     w_hit_vec;
    logic                 w_hit;
    logic [c_idx_w-1:0]   w_hit_idx;
    logic                 w_free_any;
    logic [c_idx_w-1:0]   w_free_idx;
    logic [c_tag_w-1:0]   w_dem_next_tag;
    logic                 w_dem_cross;
    logic [c_tag_w-1:0]   w_pf_next_tag;
    logic                 w_pf_cross;
    logic [ADDR_W-1:0]    w_pf_addr;

    assign w_l1_tag       = l1_mem_address[ADDR_W-1:c_off_w];
    assign w_dem_next_tag = w_l1_tag + c_tag_one;
    assign w_pf_next_tag  = r_pf_tag + c_tag_one;
    assign w_pf_addr      = {r_pf_tag, {c_off_w{1'b0}}};
    // Next line starting a page means the stream would leave the current page.
    assign w_dem_cross    = ((w_dem_next_tag & c_pg_mask) == '0);
    assign w_pf_cross     = ((w_pf_next_tag & c_pg_mask) == '0);

    // Descending scan leaves the lowest matching / free index selected.
    always_comb begin
        w_hit_vec  = '0;
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_free_any = 1'b0;
        w_free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (r_valid[i] && (r_tag[i] == w_l1_tag)) begin
                w_hit_vec[i] = 1'b1;
                w_hit        = 1'b1;
                w_hit_idx    = c_idx_w'(i);
            end
            if (!r_valid[i]) begin
                w_free_any = 1'b1;
                w_free_idx = c_idx_w'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_valid  <= '0;
            r_pf_tag <= '0;
            r_pf_cnt <= '0;
            r_alloc  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (l1_mem_read) begin
                        if (w_hit) begin
                            r_valid <= r_valid & ~w_hit_vec;
                            if (r_pf_cnt != c_depth_cnt) begin
                                r_pf_cnt <= r_pf_cnt + c_cnt_one;
                            end
                        end else begin
                            r_valid <= '0;
                            r_state <= ST_DEMAND;
                        end
                    end else if (l1_mem_write) begin
                        r_valid <= r_valid & ~w_hit_vec;
                        r_state <= ST_WRITE;
                    end else if ((r_pf_cnt != '0) && w_free_any) begin
                        r_alloc <= w_free_idx;
                        r_state <= ST_PREFETCH;
                    end
                end
                ST_DEMAND: begin
                    if (l2_mem_resp) begin
                        r_pf_tag <= w_dem_next_tag;
                        r_pf_cnt <= w_dem_cross ? '0 : c_depth_cnt;
                        r_state  <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    if (l2_mem_resp) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_PREFETCH: begin
                    if (l2_mem_resp) begin
                        r_valid[r_alloc] <= 1'b1;
                        r_pf_tag         <= w_pf_next_tag;
                        r_pf_cnt         <= w_pf_cross ? '0 : (r_pf_cnt - c_cnt_one);
                        r_state          <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Payload needs no reset: it is only observable through a valid entry.
    always_ff @(posedge clk) begin
        if ((r_state == ST_PREFETCH) && l2_mem_resp) begin
            r_tag[r_alloc]  <= r_pf_tag;
            r_data[r_alloc] <= l2_mem_rdata;
        end
    end

    always_comb begin
        l1_mem_resp    = 1'b0;
        l1_mem_rdata   = '0;
        l2_mem_read    = 1'b0;
        l2_mem_write   = 1'b0;
        l2_mem_address = '0;
        l2_mem_wdata   = '0;
        case (r_state)
            ST_IDLE: begin
                if (l1_mem_read && w_hit) begin
                    l1_mem_resp  = 1'b1;
                    l1_mem_rdata = r_data[w_hit_idx];
                end
            end
            ST_DEMAND: begin
                l2_mem_read    = 1'b1;
                l2_mem_address = l1_mem_address;
                l1_mem_resp    = l2_mem_resp;
                l1_mem_rdata   = l2_mem_rdata;
            end
            ST_WRITE: begin
                l2_mem_write   = 1'b1;
                l2_mem_address = l1_mem_address;
                l2_mem_wdata   = l1_mem_wdata;
                l1_mem_resp    = l2_mem_resp;
            end
            ST_PREFETCH: begin
                l2_mem_read    = 1'b1;
                l2_mem_address = w_pf_addr;
            end
            default: ;
        endcase
    end

`ifdef PREFETCH_STATS_EN
    logic [31:0] r_stat_hits;
    logic [31:0] r_stat_issued;
    logic [31:0] r_stat_useless;
    logic [31:0] w_useless_inc;
    logic [32:0] w_useless_sum;

    // Entries thrown away unused: whole buffer on a new stream, one on a write hit.
    always_comb begin
        w_useless_inc = '0;
        if (r_state == ST_IDLE) begin
            if (l1_mem_read && !w_hit) begin
                for (int i = 0; i < DEPTH; i++) begin
                    w_useless_inc = w_useless_inc + {31'd0, r_valid[i]};
                end
            end else if (!l1_mem_read && l1_mem_write && w_hit) begin
                w_useless_inc = 32'd1;
            end
        end
    end

    assign w_useless_sum = {1'b0, r_stat_useless} + {1'b0, w_useless_inc};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_hits    <= '0;
            r_stat_issued  <= '0;
            r_stat_useless <= '0;
        end else begin
            if ((r_state == ST_IDLE) && l1_mem_read && w_hit && (r_stat_hits != '1)) begin
                r_stat_hits <= r_stat_hits + 32'd1;
            end
            if ((r_state == ST_PREFETCH) && l2_mem_resp && (r_stat_issued != '1)) begin
                r_stat_issued <= r_stat_issued + 32'd1;
            end
            r_stat_useless <= w_useless_sum[32] ? '1 : w_useless_sum[31:0];
        end
    end

    assign stat_hits    = r_stat_hits;
    assign stat_issued  = r_stat_issued;
    assign stat_useless = r_stat_useless;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_prefetcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_prefetcher
// Brief    : Directed and randomized bench for stream_prefetcher against an
//            address-level reference model; covers PREFETCH_STATS_EN if defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_prefetcher;

    localparam int c_lb = 32;
    localparam int c_d  = 2;
    localparam logic [31:0] c_line_mask = 32'hFFFF_FFE0;

    logic         clk = 1'b0;
    logic         rst;
    logic         l1_mem_read, l1_mem_write;
    logic [31:0]  l1_mem_address;
    logic [255:0] l1_mem_wdata;
    logic         l1_mem_resp;
    logic [255:0] l1_mem_rdata;
    logic         l2_mem_read, l2_mem_write;
    logic [31:0]  l2_mem_address;
    logic [255:0] l2_mem_wdata;
    logic         l2_mem_resp;
    logic [255:0] l2_mem_rdata;
`ifdef PREFETCH_STATS_EN
    logic [31:0]  stat_hits, stat_issued, stat_useless;
`endif

    always #5 clk = ~clk;

    stream_prefetcher #(
        .ADDR_W(32), .LINE_BYTES(32), .DATA_W(256), .DEPTH(2), .PAGE_BYTES(4096)
    ) dut (
        .clk(clk), .rst(rst),
        .l1_mem_read(l1_mem_read), .l1_mem_write(l1_mem_write),
        .l1_mem_address(l1_mem_address), .l1_mem_wdata(l1_mem_wdata),
        .l1_mem_resp(l1_mem_resp), .l1_mem_rdata(l1_mem_rdata),
        .l2_mem_read(l2_mem_read), .l2_mem_write(l2_mem_write),
        .l2_mem_address(l2_mem_address), .l2_mem_wdata(l2_mem_wdata),
        .l2_mem_resp(l2_mem_resp), .l2_mem_rdata(l2_mem_rdata)
`ifdef PREFETCH_STATS_EN
        , .stat_hits(stat_hits), .stat_issued(stat_issued), .stat_useless(stat_useless)
`endif
    );

    int checks = 0;
    int failures = 0;

    // Reference model: buffer of line addresses, stream pointer and pending L2 job.
    localparam int c_p_idle = 0, c_p_demand = 1, c_p_write = 2, c_p_prefetch = 3;
    bit           m_known = 1'b0;
    int           m_phase;
    bit           m_valid [c_d];
    logic [31:0]  m_line  [c_d];
    logic [255:0] m_data  [c_d];
    logic [31:0]  m_pf_next;
    int           m_pf_cnt;
    int           m_alloc;
    int unsigned  m_hits, m_issued, m_useless;

    bit           got_resp;
    logic [255:0] got_rdata;

    int           l2_cnt = 0, l2_lat = 1, l2_fixed_lat = 2;
    logic [31:0]  log_addr[$];
    bit           log_wr[$];
    logic [255:0] log_wdata[$];

    function automatic logic [255:0] line_data(logic [31:0] a);
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = (a * (i + 3)) ^ (32'h5A5A_0000 + i);
        return d;
    endfunction

    function automatic logic [31:0] log_at(int i);
        if (i < log_addr.size()) return log_addr[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_known = 1'b1; m_phase = c_p_idle; m_pf_next = '0; m_pf_cnt = 0; m_alloc = 0;
        m_hits = 0; m_issued = 0; m_useless = 0;
        for (int i = 0; i < c_d; i++) m_valid[i] = 1'b0;
    endtask

    task automatic l2_update();
        if (l2_mem_read || l2_mem_write) begin
            if (l2_cnt == 0) begin
                l2_lat = (l2_fixed_lat > 0) ? l2_fixed_lat : int'($urandom_range(1, 3));
                log_addr.push_back(l2_mem_address);
                log_wr.push_back(l2_mem_write);
                log_wdata.push_back(l2_mem_wdata);
            end
            l2_cnt++;
            if (l2_cnt >= l2_lat) begin
                l2_mem_resp  = 1'b1;
                l2_mem_rdata = l2_mem_write ? '0 : line_data(l2_mem_address);
                l2_cnt       = 0;
            end else begin
                l2_mem_resp  = 1'b0;
                l2_mem_rdata = '0;
            end
        end else begin
            l2_cnt = 0; l2_mem_resp = 1'b0; l2_mem_rdata = '0;
        end
    endtask

    // Compare DUT outputs with the model for this cycle, then advance the model.
    task automatic model_check();
        bit           e_resp, e_rd, e_wr;
        logic [31:0]  e_addr, la;
        logic [255:0] e_rdata, e_wdata;
        int           hit, nfree, nvalid;
        e_resp = 0; e_rd = 0; e_wr = 0; e_addr = '0; e_rdata = '0; e_wdata = '0;
        la = l1_mem_address & c_line_mask;
        hit = -1;
        for (int i = 0; i < c_d; i++) if (m_valid[i] && m_line[i] == la) hit = i;
        case (m_phase)
            c_p_idle:     if (l1_mem_read && hit >= 0) begin e_resp = 1; e_rdata = m_data[hit]; end
            c_p_demand:   begin e_rd = 1; e_addr = l1_mem_address; e_resp = l2_mem_resp; e_rdata = l2_mem_rdata; end
            c_p_write:    begin e_wr = 1; e_addr = l1_mem_address; e_wdata = l1_mem_wdata; e_resp = l2_mem_resp; end
            default:      begin e_rd = 1; e_addr = m_pf_next; end
        endcase
        if (m_known) begin
            chk("l1_mem_resp", l1_mem_resp, e_resp);
            if (e_resp) chk("l1_mem_rdata", l1_mem_rdata, e_rdata);
            chk("l2_mem_read", l2_mem_read, e_rd);
            chk("l2_mem_write", l2_mem_write, e_wr);
            if (e_rd || e_wr) chk("l2_mem_address", l2_mem_address, e_addr);
            if (e_wr) chk("l2_mem_wdata", l2_mem_wdata, e_wdata);
`ifdef PREFETCH_STATS_EN
            chk("stat_hits", stat_hits, m_hits);
            chk("stat_issued", stat_issued, m_issued);
            chk("stat_useless", stat_useless, m_useless);
`endif
        end
        got_resp  = l1_mem_resp;
        got_rdata = l1_mem_rdata;
        if (rst) begin
            model_reset();
        end else if (m_known) begin
            case (m_phase)
                c_p_idle: begin
                    if (l1_mem_read) begin
                        if (hit >= 0) begin
                            m_valid[hit] = 0; m_hits++;
                            if (m_pf_cnt < c_d) m_pf_cnt++;
                        end else begin
                            nvalid = 0;
                            for (int i = 0; i < c_d; i++) begin
                                if (m_valid[i]) nvalid++;
                                m_valid[i] = 0;
                            end
                            m_useless += nvalid;
                            m_phase = c_p_demand;
                        end
                    end else if (l1_mem_write) begin
                        if (hit >= 0) begin m_valid[hit] = 0; m_useless++; end
                        m_phase = c_p_write;
                    end else if (m_pf_cnt > 0) begin
                        nfree = -1;
                        for (int i = c_d - 1; i >= 0; i--) if (!m_valid[i]) nfree = i;
                        if (nfree >= 0) begin m_alloc = nfree; m_phase = c_p_prefetch; end
                    end
                end
                c_p_demand: if (l2_mem_resp) begin
                    m_pf_next = la + c_lb;
                    m_pf_cnt  = (m_pf_next[31:12] != la[31:12]) ? 0 : c_d;
                    m_phase   = c_p_idle;
                end
                c_p_write: if (l2_mem_resp) m_phase = c_p_idle;
                default: if (l2_mem_resp) begin
                    m_valid[m_alloc] = 1; m_line[m_alloc] = m_pf_next; m_data[m_alloc] = l2_mem_rdata;
                    m_issued++;
                    m_pf_next = m_pf_next + c_lb;
                    m_pf_cnt  = (m_pf_next[11:0] == 12'h000) ? 0 : m_pf_cnt - 1;
                    m_phase   = c_p_idle;
                end
            endcase
        end
    endtask

    // Entered and left at posedge+1 with this cycle's L1 inputs already applied.
    task automatic step();
        #1 l2_update();
        @(negedge clk);
        model_check();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        repeat (n) step();
    endtask

    task automatic issue(input bit wr, input logic [31:0] a, input logic [255:0] wd, output int lat);
        l1_mem_read = !wr; l1_mem_write = wr; l1_mem_address = a; l1_mem_wdata = wd;
        lat = -1;
        for (int n = 0; n < 60; n++) begin
            step();
            if (got_resp) begin lat = n; break; end
        end
        l1_mem_read = 1'b0; l1_mem_write = 1'b0;
        if (lat < 0) begin
            checks++; failures++;
            $display("FAIL l1_timeout: addr %0h got no resp expected resp within 60 cycles", a);
        end
    endtask

    task automatic wait_log(int k);
        for (int n = 0; n < 60 && log_addr.size() < k; n++) step();
        if (log_addr.size() < k) begin
            checks++; failures++;
            $display("FAIL l2_wait: got %0d requests expected %0d", log_addr.size(), k);
        end
    endtask

    task automatic clear_log();
        log_addr.delete(); log_wr.delete(); log_wdata.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [255:0] wd;
        logic [31:0] last, a;
        logic [31:0] pool [5];
        pool[0] = 32'h0000_1000; pool[1] = 32'h0000_1FC0; pool[2] = 32'h0000_5000;
        pool[3] = 32'hFFFF_FFC0; pool[4] = 32'h0000_0FE0;
        rst = 1'b1; l1_mem_read = 0; l1_mem_write = 0; l1_mem_address = '0; l1_mem_wdata = '0;
        l2_mem_resp = 0; l2_mem_rdata = '0;
        @(posedge clk); #1;
        idle(2);
        rst = 1'b0;
        #2;
        chk("reset_l1_resp", l1_mem_resp, 0);
        chk("reset_l1_rdata", l1_mem_rdata, 0);
        chk("reset_l2_read", l2_mem_read, 0);
        chk("reset_l2_write", l2_mem_write, 0);
        @(posedge clk); #1;

        // Cold read starts a two-line stream.
        clear_log();
        issue(0, 32'h1000, '0, lat);
        chk("s1_rdata", got_rdata, line_data(32'h1000));
        chk("s1_latency", lat, 2);
        idle(8);
        chk("s1_n_l2", log_addr.size(), 3);
        chk("s1_l2_0", log_at(0), 32'h1000);
        chk("s1_l2_1", log_at(1), 32'h1020);
        chk("s1_l2_2", log_at(2), 32'h1040);

        // Buffer hit answers in the same cycle and frees a slot for 0x1060.
        clear_log();
        issue(0, 32'h1020, '0, lat);
        chk("s2_hit_latency", lat, 0);
        chk("s2_hit_rdata", got_rdata, line_data(32'h1020));
        idle(6);
        chk("s2_n_l2", log_addr.size(), 1);
        chk("s2_l2_0", log_at(0), 32'h1060);

        // Stream stops at the page boundary.
        clear_log();
        issue(0, 32'h1FC0, '0, lat);
        idle(8);
        chk("s3_n_l2", log_addr.size(), 2);
        chk("s3_l2_0", log_at(0), 32'h1FC0);
        chk("s3_l2_1", log_at(1), 32'h1FE0);

        // Demand arriving while a prefetch is outstanding waits behind it.
        l2_fixed_lat = 3;
        issue(0, 32'h1000, '0, lat);
        clear_log();
        wait_log(2);
        chk("s4_pf_pending", log_at(1), 32'h1040);
        clear_log();
        issue(0, 32'h5000, '0, lat);
        chk("s4_latency", lat, 5);
        idle(14);
        chk("s4_n_l2", log_addr.size(), 3);
        chk("s4_l2_0", log_at(0), 32'h5000);
        chk("s4_l2_1", log_at(1), 32'h5020);
        chk("s4_l2_2", log_at(2), 32'h5040);

        // Write invalidates a buffered line.
        l2_fixed_lat = 2;
        issue(0, 32'h1000, '0, lat);
        idle(10);
        clear_log();
        wd = {8{32'hC0DE_F00D}};
        issue(1, 32'h1020, wd, lat);
        issue(0, 32'h1020, '0, lat);
        chk("s5_wr_kind", log_wr.size() > 0 ? log_wr[0] : 1'b0, 1);
        chk("s5_wr_addr", log_at(0), 32'h1020);
        chk("s5_wr_data", log_wdata.size() > 0 ? log_wdata[0] : '0, wd);
        chk("s5_rd_addr", log_at(1), 32'h1020);
        chk("s5_rd_latency", lat, 2);
        idle(10);

        // Reset in the middle of a prefetch abandons it.
        l2_fixed_lat = 3;
        issue(0, 32'h1000, '0, lat);
        clear_log();
        wait_log(1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("s6_l2_read_after_rst", l2_mem_read, 0);
        clear_log();
        issue(0, 32'h1020, '0, lat);
        chk("s6_miss_addr", log_at(0), 32'h1020);
        chk("s6_miss_latency", lat, 3);
        idle(10);

        // Randomized traffic against the model.
        l2_fixed_lat = 0;
        last = 32'h1000;
        for (int it = 0; it < 300; it++) begin
            int r, p;
            r = int'($urandom_range(0, 99));
            p = int'($urandom_range(0, 3));
            a = (p < 2) ? last + 32'd32 :
                (p == 2) ? pool[$urandom_range(0, 4)] : {18'd0, 9'($urandom_range(0, 511)), 5'd0};
            if (r < 2) begin
                rst = 1'b1; step(); rst = 1'b0;
            end else if (r < 20) begin
                idle(int'($urandom_range(1, 4)));
            end else if (r < 32) begin
                wd = {8{$urandom}};
                issue(1, a, wd, lat);
            end else begin
                issue(0, a, '0, lat);
                last = a;
            end
        end
        idle(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stream_prefetcher.md
Name: stream_prefetcher

Overview:
- Parametrised sequential-stream prefetcher between the L1 cache miss port and the L2 cache. It replaces the single next-line prefetcher.
- Demand reads that miss the prefetch buffer go to L2. On completion, the block issues up to DEPTH sequential line prefetches into a small fully-associative buffer.
- L1 reads that hit the buffer are answered in the same cycle with no L2 traffic.
- Prefetching never crosses a page boundary. Writes pass through and invalidate any matching buffered line.

Parameters:
- ADDR_W, 32, address width in bits.
- LINE_BYTES, 32, cache line size in bytes (power of 2). Line tag = addr[ADDR_W-1:log2(LINE_BYTES)].
- DATA_W, 256, line data width in bits (= 8*LINE_BYTES).
- DEPTH, 2, number of buffer entries and maximum lines prefetched ahead (1..8).
- PAGE_BYTES, 4096, prefetch page-boundary size (power of 2, >= LINE_BYTES).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- l1_mem_read  in  1  L1 read request; held until l1_mem_resp
- l1_mem_write  in  1  L1 write request; held until l1_mem_resp
- l1_mem_address  in  ADDR_W  L1 request address (line aligned)
- l1_mem_wdata  in  DATA_W  L1 write line
- l1_mem_resp  out  1  one-cycle completion to L1
- l1_mem_rdata  out  DATA_W  read line, valid when l1_mem_resp=1
- l2_mem_read  out  1  L2 read request
- l2_mem_write  out  1  L2 write request
- l2_mem_address  out  ADDR_W  L2 address
- l2_mem_wdata  out  DATA_W  L2 write line
- l2_mem_resp  in  1  L2 completion
- l2_mem_rdata  in  DATA_W  L2 read line

Behaviour:
- Reset: clk, rst synchronous active-high. On reset: state=IDLE, all buffer valid bits=0, pf_cnt=0, pf_next=0.
- Reset outputs: l1_mem_resp=0, l2_mem_read=0, l2_mem_write=0, l1_mem_rdata=0. Reset mid-transaction abandons it; the L2 response of the abandoned request is ignored.
- Registered state: buffer of DEPTH entries {valid, tag, data}; pf_next (next line address to prefetch); pf_cnt (0..DEPTH, lines still to prefetch).
- Outputs: all outputs are combinational from state plus inputs.
- IDLE, buffer hit:
  - Condition: l1_mem_read=1 and the tag matches a valid entry.
  - l1_mem_resp=1 and l1_mem_rdata=entry data in the same cycle.
  - The entry is invalidated; pf_cnt increments, saturating at DEPTH. Stay IDLE.
- IDLE, buffer miss:
  - Condition: l1_mem_read=1 and no matching valid entry.
  - All entries are invalidated (new stream) and the state goes to DEMAND.
- IDLE, write: l1_mem_write=1 invalidates any matching entry and the state goes to WRITE.
- IDLE, start prefetch:
  - Condition: no L1 request, pf_cnt>0, and at least one entry free.
  - Go to PREFETCH and allocate the lowest-index free entry.
- DEMAND:
  - Drives l2_mem_read=1, l2_mem_address=l1_mem_address.
  - Passes through l1_mem_resp=l2_mem_resp and l1_mem_rdata=l2_mem_rdata.
  - On l2_mem_resp: pf_next=line(addr)+LINE_BYTES, pf_cnt=DEPTH, go to IDLE.
  - If pf_next lies in a different page from addr, pf_cnt=0.
- WRITE:
  - Drives l2_mem_write=1, l2_mem_address and l2_mem_wdata from L1, l1_mem_resp=l2_mem_resp.
  - On l2_mem_resp go to IDLE. Stream state (pf_next, pf_cnt) is unchanged.
- PREFETCH:
  - Drives l2_mem_read=1, l2_mem_address=pf_next; l1_mem_resp=0.
  - On l2_mem_resp: write {1, tag(pf_next), l2_mem_rdata} into the allocated entry, pf_next+=LINE_BYTES, pf_cnt-=1, go to IDLE.
  - If the new pf_next is at a page boundary (pf_next mod PAGE_BYTES == 0), pf_cnt=0.
- L1 request during PREFETCH: the request is stalled (no resp) until the prefetch L2 response arrives. It is then serviced from IDLE, so a just-fetched line can hit.
- l2 read and write are never asserted together. Address arithmetic wraps modulo 2^ADDR_W, but the page rule stops the stream first.
- Latency:
  - Buffer hit: 0 cycles.
  - Miss: 1 cycle plus L2 latency.
  - Demand behind a prefetch: remaining prefetch latency plus miss latency.

Optional Feature:
- Macro: PREFETCH_STATS_EN.
- When defined:
  - Adds output ports stat_hits, stat_issued, stat_useless (each 32-bit, saturating, reset to 0).
  - stat_hits counts buffer hits; stat_issued counts completed prefetches.
  - stat_useless counts valid entries discarded by a stream flush or a write invalidate.
- When undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- All scenarios use LINE_BYTES=32, DEPTH=2, PAGE_BYTES=4096.
- Cold read 0x1000, L2 returns D0 -> l1_mem_resp with D0; then l2_mem_read of 0x1020, then 0x1040, with l1_mem_resp=0 during both prefetches; buffer holds 2 valid entries.
- After scenario 1, read 0x1020 -> l1_mem_resp=1 with the 0x1020 data in the same cycle, no l2_mem_read for 0x1020; next L2 request is a prefetch of 0x1060.
- Read 0x1FC0 miss -> prefetch only 0x1FE0; no L2 request to 0x2000 or above; pf_cnt=0.
- Read 0x5000 asserted while prefetch of 0x1040 is outstanding -> 0x1040 completes first, then l2_mem_read 0x5000; after that response the buffer is flushed and prefetches go to 0x5020 and 0x5040.
- Write to 0x1020 while buffered -> l2_mem_write at 0x1020 with the L1 data; a following read of 0x1020 misses and goes to L2.
- rst asserted for one cycle mid-PREFETCH -> next cycle l2_mem_read=0, all entries invalid; a subsequent read of 0x1020 goes to L2 as a miss.
